// File: rtl/enable_pattern_sequencer_if.sv
// Bus interface for enable_pattern_sequencer: lookup request, table write
// port and registered output stream. The optional en_count signal is present
// only when EPS_POPCNT_EN is defined.
interface enable_pattern_sequencer_if #(
  parameter int IDX_W = 4,
  parameter int EN_W  = 16
);
  localparam int CNT_W = $clog2(EN_W + 1);

  logic             mode;
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [EN_W-1:0]  wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [EN_W-1:0]  out_en;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
`ifdef EPS_POPCNT_EN
  logic [CNT_W-1:0] en_count;
`endif

  // Producer of requests/writes and consumer of the output stream.
  modport master (
    output mode, req_valid, req_idx, wr_en, wr_idx, wr_data, out_ready,
    input  req_ready, out_valid, out_en, out_idx, out_last
`ifdef EPS_POPCNT_EN
    , input en_count
`endif
  );

  // The sequencer itself.
  modport slave (
    input  mode, req_valid, req_idx, wr_en, wr_idx, wr_data, out_ready,
    output req_ready, out_valid, out_en, out_idx, out_last
`ifdef EPS_POPCNT_EN
    , output en_count
`endif
  );
endinterface

// File: rtl/enable_pattern_sequencer.sv
// enable_pattern_sequencer: writable table of 2^IDX_W enable patterns.
// Lookup mode returns table[req_idx]; auto mode walks the table from index 0.
// The output is a single register stage with valid/ready.
// Optional feature macro: EPS_POPCNT_EN adds en_count (ones in out_en).
module enable_pattern_sequencer #(
  parameter int IDX_W = 4,
  parameter int EN_W  = 16
) (
  input logic clk,
  input logic rst_n,
  enable_pattern_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = $clog2(EN_W + 1);

  // Power-on pattern: entry i is one-hot, entry 0 drives the MSB.
  function automatic logic [EN_W-1:0] default_entry(input int unsigned i);
    return EN_W'(1) << (EN_W - 1 - (i % EN_W));
  endfunction

  logic [EN_W-1:0]  r_table [DEPTH];
  logic             r_mode_q;
  logic [IDX_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [EN_W-1:0]  r_out_en;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;

  logic             w_slot_free;
  logic             w_auto_rise;
  logic             w_lookup_load;
  logic             w_auto_load;
  logic             w_load;
  logic [IDX_W-1:0] w_seq_idx;
  logic [IDX_W-1:0] w_load_idx;
  logic [EN_W-1:0]  w_load_en;
  logic             w_load_last;

  // Load decision and table read for the pattern entering the output register.
  always_comb begin
    w_slot_free   = !r_out_valid || bus.out_ready;
    w_auto_rise   = bus.mode && !r_mode_q;
    w_lookup_load = bus.req_valid && w_slot_free && !bus.mode;
    w_auto_load   = bus.mode && w_slot_free;
    w_load        = w_lookup_load || w_auto_load;
    // The walk restarts at 0 in the same cycle mode rises.
    w_seq_idx     = w_auto_rise ? '0 : r_cnt;
    w_load_idx    = bus.mode ? w_seq_idx : bus.req_idx;
    w_load_en     = r_table[w_load_idx];
    w_load_last   = bus.mode && (&w_seq_idx);
  end

  assign bus.req_ready = w_slot_free && !bus.mode;

  // Pattern table; a same-cycle load sees the pre-write contents.
  // NOTE: the table is reset because defaults must reappear on every reset,
  // so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= default_entry(i);
    end else if (bus.wr_en) begin
      r_table[bus.wr_idx] <= bus.wr_data;
    end
  end

  // Mode edge detector and auto-walk counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mode_q <= bus.mode;
      if (w_auto_rise)      r_cnt <= w_slot_free ? IDX_W'(1) : '0;
      else if (w_auto_load) r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  // Output register: loads when the slot is free, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_en    <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_en    <= w_load_en;
      r_out_idx   <= w_load_idx;
      r_out_last  <= w_load_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef EPS_POPCNT_EN
  logic [CNT_W-1:0] r_en_count;

  // Population count registered in step with out_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_en_count <= '0;
    else if (w_load) r_en_count <= CNT_W'($countones(w_load_en));
  end

  assign bus.en_count = r_en_count;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_en    = r_out_en;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_enable_pattern_sequencer.sv
// Self-checking bench for enable_pattern_sequencer: directed scenarios then
// randomized traffic, all compared against a behavioural table/stream model.
module tb_enable_pattern_sequencer;
  localparam int IDX_W = 4;
  localparam int EN_W  = 16;
  localparam int DEPTH = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enable_pattern_sequencer_if #(.IDX_W(IDX_W), .EN_W(EN_W)) bus ();

  enable_pattern_sequencer #(.IDX_W(IDX_W), .EN_W(EN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [EN_W-1:0] m_tab [DEPTH];
  bit              m_valid;
  logic [EN_W-1:0] m_en;
  int              m_idx;
  bit              m_last;
  int              m_auto_loads;   // auto loads since the last entry into auto mode
  bit              m_prev_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 16'h8000 >> i;
    m_valid      = 0;
    m_en         = '0;
    m_idx        = 0;
    m_last       = 0;
    m_auto_loads = 0;
    m_prev_mode  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, bus.out_valid, m_valid);
    if (m_valid) begin
      check({tag, "_en"},   bus.out_en, m_en);
      check({tag, "_idx"},  bus.out_idx, m_idx);
      check({tag, "_last"}, bus.out_last, m_last);
`ifdef EPS_POPCNT_EN
      check({tag, "_cnt"},  bus.en_count, $countones(m_en));
`endif
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_en"},    bus.out_en, 0);
    check({tag, "_idx"},   bus.out_idx, 0);
    check({tag, "_last"},  bus.out_last, 0);
`ifdef EPS_POPCNT_EN
    check({tag, "_cnt"},   bus.en_count, 0);
`endif
  endtask

  // One clock: inputs are already driven (called just after a negedge).
  task automatic cycle(input string tag);
    bit slot_free, rise;
    int idx;
    #1;
    slot_free = !m_valid || bus.out_ready;
    check({tag, "_rdy"}, bus.req_ready, slot_free && !bus.mode);
    rise = bus.mode && !m_prev_mode;
    @(posedge clk);
    if (rise) m_auto_loads = 0;
    if (bus.mode && slot_free) begin
      idx          = m_auto_loads % DEPTH;
      m_auto_loads = m_auto_loads + 1;
      m_valid = 1; m_en = m_tab[idx]; m_idx = idx; m_last = (idx == DEPTH - 1);
    end else if (!bus.mode && slot_free && bus.req_valid) begin
      idx     = int'(bus.req_idx);
      m_valid = 1; m_en = m_tab[idx]; m_idx = idx; m_last = 0;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    if (bus.wr_en) m_tab[bus.wr_idx] = bus.wr_data;   // after the read: old data wins
    m_prev_mode = bus.mode;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.mode = 0; bus.req_valid = 0; bus.req_idx = '0;
    bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0; bus.out_ready = 1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // 1: lookups of index 0 and 5
    bus.req_valid = 1; bus.req_idx = 4'd0; cycle("t1a");
    check("t1_en0", bus.out_en, 16'h8000);
    bus.req_idx = 4'd5; cycle("t1b");
    check("t1_en5", bus.out_en, 16'h0400);
    bus.req_valid = 0; cycle("t1c");

    // 2: write and lookup of the same index in one cycle
    bus.wr_en = 1; bus.wr_idx = 4'd7; bus.wr_data = 16'h6300;
    bus.req_valid = 1; bus.req_idx = 4'd7; cycle("t2a");
    check("t2_old", bus.out_en, 16'h0100);
    bus.wr_en = 0; cycle("t2b");
    check("t2_new", bus.out_en, 16'h6300);
    bus.req_valid = 0; cycle("t2c");

    // 3: back-pressure holds the output and blocks requests
    bus.req_valid = 1; bus.req_idx = 4'd3; cycle("t3a");
    bus.out_ready = 0; bus.req_idx = 4'd9;
    bus.wr_en = 1; bus.wr_idx = 4'd3; bus.wr_data = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      cycle("t3hold");
      bus.wr_en = 0;
    end
    check("t3_stable", bus.out_en, 16'h1000);
    bus.out_ready = 1; cycle("t3b");
    check("t3_next", bus.out_idx, 9);
    bus.req_valid = 0; cycle("t3c");

    // 4: auto walk with wrap, then restart after a mode toggle
    bus.mode = 1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cycle("t4walk");
      check("t4_idx", bus.out_idx, k % DEPTH);
      check("t4_last", bus.out_last, (k % DEPTH) == DEPTH - 1);
    end
    bus.mode = 0; cycle("t4off");
    bus.mode = 1; cycle("t4on");
    check("t4_restart", bus.out_idx, 0);
    bus.mode = 0; cycle("t4d");

    // 5: reset with a programmed entry in flight
    bus.wr_en = 1; bus.wr_idx = 4'd2; bus.wr_data = 16'hABCD; cycle("t5w");
    bus.wr_en = 0; bus.req_valid = 1; bus.req_idx = 4'd2; bus.out_ready = 0; cycle("t5a");
    check("t5_pending", bus.out_en, 16'hABCD);
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1; cycle("t5b");
    check("t5_default", bus.out_en, 16'h2000);
    bus.req_valid = 0; cycle("t5c");

    // 6: popcount of a written entry
    bus.wr_en = 1; bus.wr_idx = 4'd4; bus.wr_data = 16'h002D; cycle("t6w");
    bus.wr_en = 0; bus.req_valid = 1; bus.req_idx = 4'd4; cycle("t6a");
    check("t6_en", bus.out_en, 16'h002D);
`ifdef EPS_POPCNT_EN
    check("t6_cnt", bus.en_count, 4);
`endif
    bus.req_valid = 0; cycle("t6b");

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_idx   = IDX_W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_idx    = IDX_W'($urandom);
      bus.wr_data   = EN_W'($urandom);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
